// File: rtl/param_select_sorter_if.sv
// param_select_sorter_if: host word port and sort handshake of param_select_sorter.
// Ports: start/desc/wr/addr/datain from host; dataout/ready/done (and swaps when SORT_STATS_EN) from sorter.
// master = host side, slave = sorter side.
interface param_select_sorter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);
  logic start;
  logic desc;
  logic wr;
  logic [AW-1:0] addr;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic ready;
  logic done;
`ifdef SORT_STATS_EN
  logic [AW-1:0] swaps;
`endif
  modport master (
    output start, desc, wr, addr, datain,
`ifdef SORT_STATS_EN
    input swaps,
`endif
    input dataout, ready, done
  );
  modport slave (
    input start, desc, wr, addr, datain,
`ifdef SORT_STATS_EN
    output swaps,
`endif
    output dataout, ready, done
  );
endinterface

// File: rtl/param_select_sorter.sv
// param_select_sorter: in-place selection sort of a DEPTH x WIDTH register file, ascending or descending.
// Ports: clk, nrst (async active-low), bus (param_select_sorter_if.slave: host word port + start/ready/done).
// Optional macro SORT_STATS_EN adds the swaps counter output.
module param_select_sorter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic nrst,
  param_select_sorter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, OUTER, SCAN, SWAP_A, SWAP_B, FINISH} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] i, j, min_idx, nidx, wa;
  logic [WIDTH-1:0] min_val, wd;
  logic desc_q, better, we;
  // One shared write port: host write when idle, otherwise the two halves of a swap.
  always_comb begin
    better = desc_q ? mem[j] > min_val : mem[j] < min_val;
    nidx = better ? j : min_idx;
    we = (state == IDLE && !bus.start && bus.wr) || state == SWAP_A || state == SWAP_B;
    wa = state == IDLE ? bus.addr : state == SWAP_A ? min_idx : i;
    wd = state == IDLE ? bus.datain : state == SWAP_A ? mem[i] : min_val;
  end
  // Memory is deliberately not reset so a reset mid-sort leaves the partial order in place.
  always_ff @(posedge clk)
    if (nrst && we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      min_idx <= '0;
      min_val <= '0;
      desc_q <= 1'b0;
      bus.ready <= 1'b1;
      bus.done <= 1'b0;
      bus.dataout <= '0;
`ifdef SORT_STATS_EN
      bus.swaps <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE:
          if (bus.start) begin
            desc_q <= bus.desc;
            i <= '0;
            bus.ready <= 1'b0;
            state <= OUTER;
`ifdef SORT_STATS_EN
            bus.swaps <= '0;
`endif
          end else if (!bus.wr) bus.dataout <= mem[bus.addr];
        OUTER:
          if (i == LAST) begin
            bus.done <= 1'b1;
            state <= FINISH;
          end else begin
            min_idx <= i;
            min_val <= mem[i];
            j <= i + 1'b1;
            state <= SCAN;
          end
        SCAN: begin
          // nidx already folds in this cycle's candidate, so the swap decision sees the last entry too.
          min_idx <= nidx;
          if (better) min_val <= mem[j];
          if (j == LAST) begin
            if (nidx != i) state <= SWAP_A;
            else begin
              i <= i + 1'b1;
              state <= OUTER;
            end
          end else j <= j + 1'b1;
        end
        SWAP_A: state <= SWAP_B;
        SWAP_B: begin
          i <= i + 1'b1;
          state <= OUTER;
`ifdef SORT_STATS_EN
          bus.swaps <= bus.swaps + 1'b1;
`endif
        end
        FINISH: begin
          bus.ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_select_sorter.sv
// tb_param_select_sorter: directed scoreboard bench for param_select_sorter (8x8).
module tb_param_select_sorter;
  typedef logic [7:0] arr_t [8];
  localparam arr_t D0 = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd1, 8'd8, 8'd0, 8'd5};
  localparam arr_t ASC0 = '{8'd0, 8'd1, 8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd9};
  localparam arr_t DSC0 = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd3, 8'd1, 8'd1, 8'd0};
  localparam arr_t SEQ = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  localparam arr_t D1 = '{8'd5, 8'd2, 8'd7, 8'd0, 8'd3, 8'd6, 8'd1, 8'd4};
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic rd_issue = 1'b0;
  logic rd_seen = 1'b0;
  logic [7:0] exp_q [$];
  int busy, dones;
  param_select_sorter_if #(.WIDTH(8), .DEPTH(8)) bus ();
  param_select_sorter #(.WIDTH(8), .DEPTH(8)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: a read issued in one cycle presents dataout after the next rising edge.
  always @(posedge clk) rd_seen <= rd_issue;
  always @(negedge clk)
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read: got %0h with no expected value queued", bus.dataout);
      end else chk("read", {24'd0, bus.dataout}, {24'd0, exp_q.pop_front()});
    end
  task automatic write(input logic [2:0] a, input logic [7:0] d);
    bus.wr = 1'b1;
    bus.addr = a;
    bus.datain = d;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask
  task automatic read(input logic [2:0] a, input logic [7:0] e);
    bus.wr = 1'b0;
    bus.addr = a;
    rd_issue = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    rd_issue = 1'b0;
  endtask
  task automatic load(input arr_t a);
    for (int k = 0; k < 8; k++) write(3'(k), a[k]);
  endtask
  task automatic readback(input arr_t e);
    for (int k = 0; k < 8; k++) read(3'(k), e[k]);
  endtask
  task automatic do_sort(input logic d, input bit noise, input bit wr_at_start, output int b, output int dc);
    bus.start = 1'b1;
    bus.desc = d;
    bus.wr = wr_at_start;
    bus.addr = 3'd0;
    bus.datain = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr = 1'b0;
    b = 0;
    dc = 0;
    while (!bus.ready && b < 200) begin
      if (bus.done) dc++;
      if (noise) begin
        bus.wr = 1'b1;
        bus.addr = 3'd0;
        bus.datain = 8'hFF;
        bus.start = b[0];
        bus.desc = ~b[0];
      end
      b++;
      @(negedge clk);
    end
    bus.wr = 1'b0;
    bus.start = 1'b0;
    chk("sort_timeout", {31'd0, b < 200}, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.desc = 1'b0;
    bus.wr = 1'b0;
    bus.addr = 3'd0;
    bus.datain = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_dataout", {24'd0, bus.dataout}, 32'd0);
`ifdef SORT_STATS_EN
    chk("rst_swaps", {29'd0, bus.swaps}, 32'd0);
`endif
    nrst = 1'b1;
    @(negedge clk);
    write(3'd3, 8'hA5);
    read(3'd3, 8'hA5);
    // Ascending with bus noise during the sort; dataout must keep the pre-sort read value 7.
    load(D0);
    read(3'd0, 8'd7);
    do_sort(1'b0, 1'b1, 1'b0, busy, dones);
    chk("asc_busy", busy, 32'd47);
    chk("asc_done_pulses", dones, 32'd1);
    chk("asc_ready", {31'd0, bus.ready}, 32'd1);
    chk("asc_dataout_hold", {24'd0, bus.dataout}, 32'd7);
`ifdef SORT_STATS_EN
    chk("asc_swaps", {29'd0, bus.swaps}, 32'd5);
`endif
    readback(ASC0);
    load(D0);
    do_sort(1'b1, 1'b0, 1'b0, busy, dones);
    chk("desc_busy", busy, 32'd47);
    chk("desc_done_pulses", dones, 32'd1);
`ifdef SORT_STATS_EN
    chk("desc_swaps", {29'd0, bus.swaps}, 32'd5);
`endif
    readback(DSC0);
    // Already sorted, with a write of FF to addr 0 in the start cycle that must be dropped.
    load(SEQ);
    do_sort(1'b0, 1'b0, 1'b1, busy, dones);
    chk("sorted_busy", busy, 32'd37);
    chk("sorted_done_pulses", dones, 32'd1);
`ifdef SORT_STATS_EN
    chk("sorted_swaps", {29'd0, bus.swaps}, 32'd0);
`endif
    readback(SEQ);
    // Reset 10 cycles into a sort.
    load(D0);
    bus.start = 1'b1;
    bus.desc = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
`ifdef SORT_STATS_EN
    chk("midrst_swaps", {29'd0, bus.swaps}, 32'd0);
`endif
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    load(D1);
    do_sort(1'b0, 1'b0, 1'b0, busy, dones);
    chk("resort_busy", busy, 32'd51);
    chk("resort_done_pulses", dones, 32'd1);
`ifdef SORT_STATS_EN
    chk("resort_swaps", {29'd0, bus.swaps}, 32'd7);
`endif
    readback(SEQ);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
